boot_loader: RTL and testbench

- Upstream program-loading stage for the single-cycle CPU.
- Accepts a word stream over a valid/ready handshake: header, then instruction words, then data words.
- Drives the CPU's memory-load ports (address, inst_data, write_instruction, write_data) while holding the CPU in reset.
- Releases CPU reset once loading completes, replacing hand-driven load sequences in benches and board bring-up.

---
 rtl/boot_loader_pkg.sv | 29 ++
 rtl/boot_loader_hdr_check.sv | 29 ++
 rtl/boot_loader.sv | 188 ++++++++++++++++++
 tb/tb_boot_loader.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_loader_pkg.sv
// boot_loader_pkg: shared types and constants for the boot loader.
// State enum, header field positions and memory size helpers.
package boot_loader_pkg;

   typedef enum logic [2:0] {
      HDR,
      LOAD_I,
      LOAD_D,
      CHK,
      RELEASE,
      RUN,
      ERR
   } state_t;

   localparam int DEF_ADDR_W = 10;
   localparam int MEM_WORDS  = 1 << DEF_ADDR_W;

   localparam int BASE_MSB = 31;
   localparam int BASE_LSB = 22;
   localparam int NI_MSB   = 21;
   localparam int NI_LSB   = 11;
   localparam int ND_MSB   = 10;
   localparam int ND_LSB   = 0;

   function automatic int mem_words(input int aw);
      return 1 << aw;
   endfunction

endpackage

// File: rtl/boot_loader_hdr_check.sv
// boot_loader_hdr_check: combinational header decode and validity check.
// Ports: hdr in; data_base, n_instr, n_data, hdr_ok out.
module boot_loader_hdr_check
   import boot_loader_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] hdr,
   output logic [9:0]        data_base,
   output logic [10:0]       n_instr,
   output logic [10:0]       n_data,
   output logic              hdr_ok
);

   localparam logic [11:0] LIMIT = 12'(mem_words(ADDR_W));

   logic [11:0] top;

   // 12-bit sum so base + count cannot wrap past the limit
   always_comb begin
      data_base = hdr[BASE_MSB:BASE_LSB];
      n_instr   = hdr[NI_MSB:NI_LSB];
      n_data    = hdr[ND_MSB:ND_LSB];
      top       = {2'b00, data_base} + {1'b0, n_data};
      hdr_ok    = ({1'b0, n_instr} <= LIMIT) && (top <= LIMIT);
   end

endmodule

// File: rtl/boot_loader.sv
// boot_loader: streams header/instr/data words into CPU memories, then
// releases CPU reset. Ports: clk, rst, in_data/in_valid/in_ready stream,
// reload, address/inst_data/write_instruction/write_data load port,
// cpu_rst, done, error. Optional macro: BOOT_LOADER_CHECKSUM_EN.
module boot_loader
   import boot_loader_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int DATA_W      = 32,
   parameter int HOLD_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              reload,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] inst_data,
   output logic              write_instruction,
   output logic              write_data,
   output logic              cpu_rst,
   output logic              done,
   output logic              error
);

   state_t state, state_nxt;

   logic              armed;
   logic              xfer;
   logic              last_i;
   logic              last_d;
   logic              hold_done;
   logic [10:0]       cnt;
   logic [10:0]       n_i_q;
   logic [10:0]       n_d_q;
   logic [9:0]        base_q;
   logic [3:0]        hold_cnt;
   logic [ADDR_W-1:0] d_addr;

   logic [9:0]        h_base;
   logic [10:0]       h_ni;
   logic [10:0]       h_nd;
   logic              h_ok;

`ifdef BOOT_LOADER_CHECKSUM_EN
   localparam state_t TAIL = CHK;
   logic [DATA_W-1:0] sum;
`else
   localparam state_t TAIL = RELEASE;
`endif

   boot_loader_hdr_check #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_hdr (
      .hdr       (in_data),
      .data_base (h_base),
      .n_instr   (h_ni),
      .n_data    (h_nd),
      .hdr_ok    (h_ok)
   );

   assign xfer      = in_valid & in_ready;
   assign last_i    = (cnt == n_i_q - 11'd1);
   assign last_d    = (cnt == n_d_q - 11'd1);
   assign hold_done = (hold_cnt == 4'(HOLD_CYCLES));
   assign d_addr    = ADDR_W'({1'b0, base_q} + cnt);

   // armed keeps in_ready low for the first cycle out of reset
   always_comb begin
      in_ready = 1'b0;
      unique case (state)
         HDR:                 in_ready = armed;
         LOAD_I, LOAD_D, CHK: in_ready = 1'b1;
         default:             in_ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= HDR;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cpu_rst   = 1'b1;
      done      = 1'b0;
      error     = 1'b0;
      unique case (state)
         HDR: begin
            if (xfer) begin
               if (!h_ok)              state_nxt = ERR;
               else if (h_ni != 11'd0) state_nxt = LOAD_I;
               else if (h_nd != 11'd0) state_nxt = LOAD_D;
               else                    state_nxt = TAIL;
            end
         end
         LOAD_I: begin
            if (xfer && last_i)
               state_nxt = (n_d_q != 11'd0) ? LOAD_D : TAIL;
         end
         LOAD_D: begin
            if (xfer && last_d) state_nxt = TAIL;
         end
`ifdef BOOT_LOADER_CHECKSUM_EN
         CHK: begin
            if (xfer)
               state_nxt = (in_data == sum) ? RELEASE : ERR;
         end
`endif
         RELEASE: begin
            if (hold_done) state_nxt = RUN;
         end
         RUN: begin
            cpu_rst = 1'b0;
            done    = 1'b1;
            if (reload) state_nxt = HDR;
         end
         ERR: begin
            error = 1'b1;
            if (reload) state_nxt = HDR;
         end
         default: state_nxt = HDR;
      endcase
   end

   // release counter spans the strobe cycle plus HOLD_CYCLES more
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         armed             <= 1'b0;
         cnt               <= '0;
         n_i_q             <= '0;
         n_d_q             <= '0;
         base_q            <= '0;
         hold_cnt          <= '0;
         address           <= '0;
         inst_data         <= '0;
         write_instruction <= 1'b0;
         write_data        <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
         sum               <= '0;
`endif
      end else begin
         armed             <= 1'b1;
         write_instruction <= 1'b0;
         write_data        <= 1'b0;
         hold_cnt <= (state == RELEASE) ? hold_cnt + 4'd1 : 4'd0;
         unique case (state)
            HDR: begin
               if (xfer) begin
                  base_q <= h_base;
                  n_i_q  <= h_ni;
                  n_d_q  <= h_nd;
                  cnt    <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
                  sum    <= in_data;
`endif
               end
            end
            LOAD_I: begin
               if (xfer) begin
                  address           <= cnt[ADDR_W-1:0];
                  inst_data         <= in_data;
                  write_instruction <= 1'b1;
                  cnt <= last_i ? 11'd0 : cnt + 11'd1;
`ifdef BOOT_LOADER_CHECKSUM_EN
                  sum <= sum + in_data;
`endif
               end
            end
            LOAD_D: begin
               if (xfer) begin
                  address    <= d_addr;
                  inst_data  <= in_data;
                  write_data <= 1'b1;
                  cnt <= last_d ? 11'd0 : cnt + 11'd1;
`ifdef BOOT_LOADER_CHECKSUM_EN
                  sum <= sum + in_data;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: randomized self-checking bench for boot_loader.
// Compares observed memory writes and release timing to a program model.
module tb_boot_loader;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 32;
   localparam int HOLD   = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic              reload;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] inst_data;
   logic              write_instruction;
   logic              write_data;
   logic              cpu_rst;
   logic              done;
   logic              error;

   boot_loader #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .HOLD_CYCLES (HOLD)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .in_data           (in_data),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .reload            (reload),
      .address           (address),
      .inst_data         (inst_data),
      .write_instruction (write_instruction),
      .write_data        (write_data),
      .cpu_rst           (cpu_rst),
      .done              (done),
      .error             (error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      bit          is_d;
      int          addr;
      logic [31:0] data;
   } wr_t;

   wr_t wq[$];
   int  dual = 0;
   int  n_checks = 0;
   int  n_fail = 0;

   logic [31:0] spec_pay[$] = '{32'h07E0000A, 32'h06C0000A,
                                32'h00FFD800, 32'd7};

   always @(negedge clk) begin
      if (write_instruction && write_data) dual++;
      if (write_instruction)
         wq.push_back('{cyc, 1'b0, int'(address), inst_data});
      else if (write_data)
         wq.push_back('{cyc, 1'b1, int'(address), inst_data});
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] mk_hdr(input int b, input int ni,
                                          input int nd);
      logic [31:0] h;
      h = {b[9:0], ni[10:0], nd[10:0]};
      return h;
   endfunction

   task automatic rand_words(input int n, output logic [31:0] q[$]);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back($urandom);
   endtask

   // bubble mode inserts 1-2 idle cycles (with stray reload pulses)
   task automatic send(input logic [31:0] w, input bit bub,
                       output int hs, output bit ok);
      int gaps;
      ok = 1'b0;
      hs = -1;
      gaps = bub ? 1 + int'($urandom_range(0, 1)) : 0;
      for (int t = 0; t < 64 && !ok; t++) begin
         @(negedge clk);
         if (gaps > 0) begin
            gaps--;
            in_valid = 1'b0;
            in_data  = $urandom;
            reload   = bub ? 1'($urandom_range(0, 1)) : 1'b0;
         end else begin
            reload   = 1'b0;
            in_valid = 1'b1;
            in_data  = w;
            if (in_ready) begin
               ok = 1'b1;
               hs = cyc;
            end
         end
      end
   endtask

   task automatic do_reload(input string name);
      @(negedge clk);
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      n_checks++;
      if (done !== 1'b0 || error !== 1'b0 || cpu_rst !== 1'b1 ||
          in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s reload: done=%b error=%b cpu_rst=%b rdy=%b, want 0 0 1 1",
                  name, done, error, cpu_rst, in_ready);
      end
   endtask

   task automatic run_prog(input string name, input int base,
                           input int ni, input int nd,
                           input logic [31:0] pay[$], input bit bub);
      logic [31:0] hdr;
      logic [31:0] sum;
      wr_t         exp[$];
      int          hs[$];
      int          last, t, fall, tmo, bad, badl, n;
      bit          ok, valid, spaced;
      hdr   = mk_hdr(base, ni, nd);
      valid = (ni <= 1024) && (base + nd <= 1024);
      for (int i = 0; i < ni; i++)
         exp.push_back('{0, 1'b0, i, pay[i]});
      for (int j = 0; j < nd; j++)
         exp.push_back('{0, 1'b1, base + j, pay[ni + j]});
      wq.delete();
      dual = 0;
      tmo  = 0;
      send(hdr, bub, last, ok);
      if (!ok) tmo++;
      sum = hdr;
      if (valid) begin
         for (int i = 0; i < ni + nd; i++) begin
            send(pay[i], bub, t, ok);
            if (!ok) tmo++;
            hs.push_back(t);
            last = t;
            sum += pay[i];
         end
`ifdef BOOT_LOADER_CHECKSUM_EN
         send(sum, bub, last, ok);
         if (!ok) tmo++;
`endif
      end
      @(negedge clk);
      in_valid = 1'b0;
      reload   = 1'b0;
      n_checks++;
      if (tmo != 0) begin
         n_fail++;
         $display("FAIL %s handshake: %0d words timed out, want 0", name, tmo);
      end
      if (valid) begin
         fall = -1;
         for (int k = 0; k < 64 && fall < 0; k++) begin
            if (!cpu_rst) fall = cyc;
            else @(negedge clk);
         end
         n_checks++;
         if (fall != last + HOLD + 2) begin
            n_fail++;
            $display("FAIL %s cpu_rst release: cycle %0d, want %0d",
                     name, fall, last + HOLD + 2);
         end
         n_checks++;
         if (done !== 1'b1 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL %s run flags: done=%b error=%b, want 1 0",
                     name, done, error);
         end
         n_checks++;
         if (wq.size() != exp.size()) begin
            n_fail++;
            $display("FAIL %s write count: %0d, want %0d",
                     name, wq.size(), exp.size());
         end
         n = (wq.size() < exp.size()) ? wq.size() : exp.size();
         bad = 0;
         badl = 0;
         spaced = 1'b1;
         for (int i = 0; i < n; i++) begin
            if (wq[i].is_d != exp[i].is_d || wq[i].addr != exp[i].addr ||
                wq[i].data !== exp[i].data) begin
               if (bad == 0)
                  $display("FAIL %s write %0d: got d=%b a=%0d %h, want d=%b a=%0d %h",
                           name, i, wq[i].is_d, wq[i].addr, wq[i].data,
                           exp[i].is_d, exp[i].addr, exp[i].data);
               bad++;
            end
            if (wq[i].cyc != hs[i] + 1) badl++;
            if (i > 0 && wq[i].cyc == wq[i-1].cyc + 1) spaced = 1'b0;
         end
         n_checks++;
         if (bad != 0) n_fail++;
         n_checks++;
         if (badl != 0) begin
            n_fail++;
            $display("FAIL %s write latency: %0d strobes off, want 0",
                     name, badl);
         end
         if (bub) begin
            n_checks++;
            if (!spaced) begin
               n_fail++;
               $display("FAIL %s bubbles: back-to-back strobes, want none",
                        name);
            end
         end
         n_checks++;
         if (dual != 0) begin
            n_fail++;
            $display("FAIL %s dual strobe: %0d cycles, want 0", name, dual);
         end
         repeat (3) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = $urandom;
         end
         @(negedge clk);
         in_valid = 1'b0;
         n_checks++;
         if (wq.size() != exp.size() || done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s run ignores stream: writes=%0d done=%b, want %0d 1",
                     name, wq.size(), done, exp.size());
         end
      end else begin
         repeat (3) @(negedge clk);
         n_checks++;
         if (error !== 1'b1 || cpu_rst !== 1'b1 || done !== 1'b0 ||
             in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s err flags: error=%b cpu_rst=%b done=%b rdy=%b, want 1 1 0 0",
                     name, error, cpu_rst, done, in_ready);
         end
         n_checks++;
         if (wq.size() != 0) begin
            n_fail++;
            $display("FAIL %s err writes: %0d, want 0", name, wq.size());
         end
      end
      do_reload(name);
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      reload   = 1'b0;
      @(negedge clk);
      n_checks++;
      if (cpu_rst !== 1'b1 || in_ready !== 1'b0 || address !== '0 ||
          inst_data !== '0 || write_instruction !== 1'b0 ||
          write_data !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
         n_fail++;
         $display("FAIL reset values: rst=%b rdy=%b a=%0d d=%h wi=%b wd=%b dn=%b er=%b",
                  cpu_rst, in_ready, address, inst_data,
                  write_instruction, write_data, done, error);
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL first ready: %b, want 0", in_ready);
      end
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL hdr ready: %b, want 1", in_ready);
      end
   endtask

   task automatic test_stream();
      run_prog("spec_stream", 10, 3, 1, spec_pay, 1'b0);
   endtask

   task automatic test_bubbles();
      run_prog("spec_bubbles", 10, 3, 1, spec_pay, 1'b1);
   endtask

   task automatic test_empty();
      logic [31:0] q[$];
      run_prog("empty", 0, 0, 0, q, 1'b0);
   endtask

   task automatic test_bad_header();
      logic [31:0] q[$];
      rand_words(5, q);
      run_prog("bad_base", 1020, 0, 5, q, 1'b0);
      run_prog("after_err", 10, 3, 1, spec_pay, 1'b0);
   endtask

   task automatic test_boundary();
      logic [31:0] q[$];
      rand_words(5, q);
      run_prog("base_top", 1019, 0, 5, q, 1'b0);
      q.delete();
      run_prog("ni_over", 0, 1025, 0, q, 1'b0);
      rand_words(1024, q);
      run_prog("ni_full", 0, 1024, 0, q, 1'b0);
      rand_words(1024, q);
      run_prog("nd_full", 0, 0, 1024, q, 1'b0);
   endtask

   task automatic test_mid_reset();
      int t;
      bit ok;
      send(mk_hdr(10, 3, 1), 1'b0, t, ok);
      send(spec_pay[0], 1'b0, t, ok);
      send(spec_pay[1], 1'b0, t, ok);
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++;
      if (write_instruction !== 1'b1 || address !== 10'd1 ||
          inst_data !== spec_pay[1]) begin
         n_fail++;
         $display("FAIL mid load word1: wi=%b a=%0d d=%h, want 1 1 %h",
                  write_instruction, address, inst_data, spec_pay[1]);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (cpu_rst !== 1'b1 || in_ready !== 1'b0 || address !== '0 ||
          inst_data !== '0 || write_instruction !== 1'b0 ||
          write_data !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
         n_fail++;
         $display("FAIL mid reset: rst=%b rdy=%b a=%0d d=%h wi=%b wd=%b dn=%b er=%b",
                  cpu_rst, in_ready, address, inst_data,
                  write_instruction, write_data, done, error);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_prog("mid_restream", 10, 3, 1, spec_pay, 1'b0);
   endtask

   task automatic test_random();
      logic [31:0] q[$];
      int b, ni, nd;
      for (int r = 0; r < 10; r++) begin
         b  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1012, 1023))
                                          : int'($urandom_range(0, 1023));
         ni = int'($urandom_range(0, 6));
         nd = int'($urandom_range(0, 6));
         rand_words(ni + nd, q);
         run_prog($sformatf("rand%0d", r), b, ni, nd, q, r[0]);
      end
   endtask

`ifdef BOOT_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      logic [31:0] q[$];
      logic [31:0] hdr;
      int t;
      bit ok;
      q.push_back(32'd5);
      run_prog("chk_good", 0, 1, 0, q, 1'b0);
      hdr = mk_hdr(0, 1, 0);
      wq.delete();
      send(hdr, 1'b0, t, ok);
      send(32'd5, 1'b0, t, ok);
      send(hdr + 32'd6, 1'b0, t, ok);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (HOLD + 3) @(negedge clk);
      n_checks++;
      if (error !== 1'b1 || cpu_rst !== 1'b1 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL chk_bad flags: error=%b cpu_rst=%b done=%b, want 1 1 0",
                  error, cpu_rst, done);
      end
      n_checks++;
      if (wq.size() != 1) begin
         n_fail++;
         $display("FAIL chk_bad writes: %0d, want 1", wq.size());
      end
      do_reload("chk_bad");
   endtask
`endif

   initial begin
      test_reset();
      test_stream();
      test_bubbles();
      test_empty();
      test_bad_header();
      test_boundary();
      test_mid_reset();
      test_random();
`ifdef BOOT_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
